i2c_target_regs: RTL and testbench
==================================

# i2c_target_regs

Synchronous, parametrised I2C target that exposes a 2^PTR_W-entry register space to an I2C controller. It is the next generation of the team's I2C peripheral: SCL and SDA are oversampled in the system clock domain rather than used as clocks. It adds a register pointer with auto-increment, multi-byte read and write bursts, repeated-start handling and a glitch filter. It sits between the board I2C pins and the design's control/status register file.

## Interface
- ADDRESS, 7'h42, 7-bit target address matched against the first byte after START.
- PTR_W, 4, register pointer width; register space is 2^PTR_W bytes.
- FILTER, 3, number of consecutive identical synchronised samples required before a filtered SCL/SDA level changes (≥1).
- clk  input  1  system clock, ≥ 20× SCL frequency.
- reset_n  input  1  asynchronous, active-low reset.
- scl  inout  1  I2C clock; input only, never driven (constant 1'bz).
- sda  inout  1  I2C data; open-drain: driven 0 when the output enable is high, else 1'bz.
- reg_addr  output  PTR_W  current register pointer.
- reg_wr_data  output  8  byte being written; valid with reg_wr_en.
- reg_wr_en  output  1  one-clk pulse; write reg_wr_data to reg_addr.
- reg_rd_data  input  8  contents of register reg_addr; sampled combinationally by the block.
- reg_rd_en  output  1  one-clk pulse when reg_rd_data is captured for transmission.
- busy  output  1  high from an addressed START (address match) until STOP.

## Operation
- Input path: each of scl/sda passes through a 2-flop synchroniser, then a FILTER-sample majority/stability filter. Edge detect on the filtered signals produces scl_rise, scl_fall, start (sda fall while scl high) and stop (sda rise while scl high).
- Reset: all outputs 0, reg_addr=0, sda released, state IDLE, bit counter 0.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP.
- start from any state -> ADDR; bit counter=0; sda released. A repeated start is handled identically, and reg_addr is preserved.
- stop from any state -> IDLE; busy=0; sda released.
- ADDR: shift sda MSB-first on scl_rise; after the 8th bit -> ADDR_ACK if bits[7:1]==ADDRESS, else WAIT_STOP (never drive sda).
- ADDR_ACK: drive sda low from the next scl_fall until the scl_fall after the ACK clock; busy=1. If R/W=0 -> PTR. If R/W=1 -> RDATA, capturing reg_rd_data into the TX shift register at the ACK-ending scl_fall and pulsing reg_rd_en.
- PTR: receive 8 bits; reg_addr <= byte[PTR_W-1:0] (upper bits ignored); ACK -> WDATA.
- WDATA: receive 8 bits; at the 8th scl_rise assert reg_wr_data and pulse reg_wr_en for one clk. Then ACK (WDATA_ACK) and post-increment reg_addr modulo 2^PTR_W -> WDATA.
- RDATA: drive the shift register MSB-first, changing sda only one clk after scl_fall; after 8 bits release sda -> RDATA_ACK.
- RDATA_ACK: sample sda at scl_rise. On 0 (ACK), increment reg_addr (wrap), capture reg_rd_data at the next scl_fall, pulse reg_rd_en and return to RDATA. On 1 (NACK), go to WAIT_STOP.
- WAIT_STOP: sda released; leave only on start or stop.
- Simultaneous stop and start in the same clk cannot occur; if scl_rise and start coincide, start wins.

## Timing
- Input latency: 2 sync clks + FILTER clks from pin to filtered level; events are 1 clk after that.
- sda drive/release changes exactly 1 clk after the internal scl_fall event. This gives data hold on the bus and never changes sda while filtered scl is high.
- reg_wr_en asserts 1 clk after the internal scl_rise of the 8th data bit; reg_wr_data is stable on that cycle.
- reg_rd_data must be valid in the same clk that reg_rd_en pulses; there is no wait state.
- reset_n deassertion mid-transaction: the block returns to IDLE and ignores the bus until the next start.
- No clock stretching; scl is never driven.

## Test plan
- Write burst: START, 0x84, 0x03, 0xAA, 0x55, STOP -> 3 ACKs; reg_wr_en pulses with (addr 3, 0xAA) then (4, 0x55); reg_addr=5; busy falls at STOP.
- Read with repeated start: START 0x84 0x0E, Sr 0x85, read 3 bytes (ACK, ACK, NACK) with reg_rd_data=addr×0x11 -> bytes 0xEE, 0xFF, 0x00 (pointer wraps 15->0); sda released after NACK.
- Address mismatch: START 0x86 0x01 STOP -> no ACK (sda never low from target), no reg_wr_en, busy stays 0.
- Glitch rejection: 1-clk pulses on scl and sda while idle and mid-byte -> no state or bit-count change; the transfer completes correctly.
- Reset mid-read: assert reset_n low during bit 4 of RDATA -> sda released immediately, outputs 0; the next full write transaction succeeds.
- Stop mid-byte: STOP after 5 bits of WDATA -> IDLE, no reg_wr_en, reg_addr unchanged.

Source files
------------

// File: rtl/i2c_target_regs.sv
// rtl/i2c_target_regs.sv - oversampled I2C target exposing a pointer-addressed register space
module i2c_target_regs #(
    parameter logic [6:0] ADDRESS = 7'h42,
    parameter int         PTR_W   = 4,
    parameter int         FILTER  = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    inout  wire              scl,
    inout  wire              sda,
    output logic [PTR_W-1:0] reg_addr,
    output logic [7:0]       reg_wr_data,
    output logic             reg_wr_en,
    input  logic [7:0]       reg_rd_data,
    output logic             reg_rd_en,
    output logic             busy
);
    localparam int CW = $clog2(FILTER) + 1;

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP
    } state_t;

    // bit 1 carries scl, bit 0 carries sda through the whole input path
    logic [1:0]    s1_q, s2_q, filt_q, prev_q;
    logic [CW-1:0] fcnt_q [2];

    logic scl_rise, scl_fall, start_ev, stop_ev;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [6:0]       sh_q, sh_d;
    logic [7:0]       tx_q, tx_d;
    logic             oe_q, oe_d;
    logic [PTR_W-1:0] addr_q, addr_d;
    logic             wr_en_q, wr_en_d;
    logic [7:0]       wr_data_q, wr_data_d;
    logic             busy_q, busy_d;
    logic             rw_q, rw_d;
    logic             rd_en;
    logic [7:0]       rx_byte;

    assign scl = 1'bz;
    assign sda = oe_q ? 1'b0 : 1'bz;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q      <= 2'b11;
            s2_q      <= 2'b11;
            filt_q    <= 2'b11;
            prev_q    <= 2'b11;
            fcnt_q[0] <= '0;
            fcnt_q[1] <= '0;
        end else begin
            s1_q   <= {scl, sda};
            s2_q   <= s1_q;
            prev_q <= filt_q;
            // the filtered level only follows after FILTER consecutive differing samples
            for (int i = 0; i < 2; i++) begin
                if (s2_q[i] == filt_q[i]) begin
                    fcnt_q[i] <= '0;
                end else if (fcnt_q[i] == CW'(FILTER - 1)) begin
                    filt_q[i] <= s2_q[i];
                    fcnt_q[i] <= '0;
                end else begin
                    fcnt_q[i] <= fcnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign scl_rise = filt_q[1] & ~prev_q[1];
    assign scl_fall = ~filt_q[1] & prev_q[1];
    assign start_ev = filt_q[1] & prev_q[1] & prev_q[0] & ~filt_q[0];
    assign stop_ev  = filt_q[1] & prev_q[1] & ~prev_q[0] & filt_q[0];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sh_d      = sh_q;
        tx_d      = tx_q;
        oe_d      = oe_q;
        addr_d    = addr_q;
        wr_en_d   = 1'b0;
        wr_data_d = wr_data_q;
        busy_d    = busy_q;
        rw_d      = rw_q;
        rd_en     = 1'b0;
        rx_byte   = {sh_q, filt_q[0]};
        if (start_ev) begin
            state_d = ADDR;
            cnt_d   = '0;
            oe_d    = 1'b0;
        end else if (stop_ev) begin
            state_d = IDLE;
            cnt_d   = '0;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                ADDR, PTR, WDATA: begin
                    if (scl_rise) begin
                        sh_d  = rx_byte[6:0];
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            cnt_d = '0;
                            case (state_q)
                                ADDR: begin
                                    if (rx_byte[7:1] == ADDRESS) begin
                                        state_d = ADDR_ACK;
                                        rw_d    = rx_byte[0];
                                        busy_d  = 1'b1;
                                    end else begin
                                        state_d = WAIT_STOP;
                                    end
                                end
                                PTR: begin
                                    addr_d  = rx_byte[PTR_W-1:0];
                                    state_d = PTR_ACK;
                                end
                                default: begin
                                    wr_en_d   = 1'b1;
                                    wr_data_d = rx_byte;
                                    state_d   = WDATA_ACK;
                                end
                            endcase
                        end
                    end
                end
                ADDR_ACK, PTR_ACK, WDATA_ACK: begin
                    // first scl_fall starts the ACK drive, the second one ends it
                    if (scl_fall) begin
                        if (!oe_q) begin
                            oe_d = 1'b1;
                        end else begin
                            oe_d = 1'b0;
                            case (state_q)
                                ADDR_ACK: begin
                                    if (rw_q) begin
                                        state_d = RDATA;
                                        tx_d    = reg_rd_data;
                                        oe_d    = ~reg_rd_data[7];
                                        rd_en   = 1'b1;
                                    end else begin
                                        state_d = PTR;
                                    end
                                end
                                PTR_ACK: state_d = WDATA;
                                default: begin
                                    state_d = WDATA;
                                    addr_d  = addr_q + 1'b1;
                                end
                            endcase
                        end
                    end
                end
                RDATA: begin
                    if (scl_rise) begin
                        cnt_d = cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (cnt_q == 4'd8) begin
                            oe_d    = 1'b0;
                            cnt_d   = '0;
                            state_d = RDATA_ACK;
                        end else begin
                            oe_d = ~tx_q[3'd7 - cnt_q[2:0]];
                        end
                    end
                end
                RDATA_ACK: begin
                    if (scl_rise) begin
                        if (filt_q[0]) state_d = WAIT_STOP;
                        else           addr_d  = addr_q + 1'b1;
                    end else if (scl_fall) begin
                        state_d = RDATA;
                        tx_d    = reg_rd_data;
                        oe_d    = ~reg_rd_data[7];
                        rd_en   = 1'b1;
                        cnt_d   = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sh_q      <= '0;
            tx_q      <= '0;
            oe_q      <= 1'b0;
            addr_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            rw_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sh_q      <= sh_d;
            tx_q      <= tx_d;
            oe_q      <= oe_d;
            addr_q    <= addr_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            rw_q      <= rw_d;
        end
    end

    assign reg_addr    = addr_q;
    assign reg_wr_data = wr_data_q;
    assign reg_wr_en   = wr_en_q;
    assign reg_rd_en   = rd_en;
    assign busy        = busy_q;
endmodule

// File: tb/tb_i2c_target_regs.sv
// tb/tb_i2c_target_regs.sv - bus-level bench for i2c_target_regs with write/read scoreboards
module tb_i2c_target_regs;
    localparam int Q = 10;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       scl_lo = 1'b0;
    logic       sda_lo = 1'b0;
    wire        scl;
    wire        sda;
    logic [3:0] reg_addr;
    logic [7:0] reg_wr_data;
    logic       reg_wr_en;
    logic [7:0] reg_rd_data;
    logic       reg_rd_en;
    logic       busy;

    assign scl = scl_lo ? 1'b0 : 1'bz;
    assign sda = sda_lo ? 1'b0 : 1'bz;
    pullup (scl);
    pullup (sda);

    // register file model: every register reads back as its address times 0x11
    assign reg_rd_data = {reg_addr, reg_addr};

    i2c_target_regs dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .scl         (scl),
        .sda         (sda),
        .reg_addr    (reg_addr),
        .reg_wr_data (reg_wr_data),
        .reg_wr_en   (reg_wr_en),
        .reg_rd_data (reg_rd_data),
        .reg_rd_en   (reg_rd_en),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [3:0] a;
        logic [7:0] d;
    } wr_t;

    wr_t        wr_exp[$];
    wr_t        wr_e;
    logic [7:0] rd_exp[$];
    int         rd_cnt   = 0;
    int         nd_viol  = 0;
    int         busy_hit = 0;
    logic       nd_watch = 1'b0;

    always @(negedge clk) begin
        if (reset_n && reg_wr_en) begin
            if (wr_exp.size() == 0) begin
                check("wr_unexpected", 1, 0);
            end else begin
                wr_e = wr_exp.pop_front();
                check("wr_addr", reg_addr, wr_e.a);
                check("wr_data", reg_wr_data, wr_e.d);
            end
        end
        if (reg_rd_en) rd_cnt++;
        if (nd_watch && !sda_lo && sda === 1'b0) nd_viol++;
        if (nd_watch && busy) busy_hit++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_cycle(input logic b, input logic glitch, output logic smp);
        tick(Q);
        sda_lo = ~b;
        tick(Q);
        scl_lo = 1'b0;
        if (glitch) begin
            tick(3);
            scl_lo = 1'b1;
            tick(1);
            scl_lo = 1'b0;
            tick(3);
            sda_lo = b;
            tick(1);
            sda_lo = ~b;
            tick(Q - 8);
        end else begin
            tick(Q);
        end
        smp = sda;
        tick(Q);
        scl_lo = 1'b1;
    endtask

    task automatic start_cond;
        sda_lo = 1'b0;
        tick(Q);
        scl_lo = 1'b0;
        tick(Q);
        sda_lo = 1'b1;
        tick(Q);
        scl_lo = 1'b1;
    endtask

    task automatic stop_cond;
        sda_lo = 1'b1;
        tick(Q);
        scl_lo = 1'b0;
        tick(Q);
        sda_lo = 1'b0;
        tick(Q);
    endtask

    task automatic send_byte(input logic [7:0] d, input int gbit, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_cycle(d[i], i == gbit, s);
        bit_cycle(1'b1, 1'b0, s);
        ack = ~s;
    endtask

    task automatic recv_byte(input logic mack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_cycle(1'b1, 1'b0, s);
            d[i] = s;
        end
        bit_cycle(~mack, 1'b0, s);
    endtask

    typedef struct {
        logic [7:0] ptr;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [3:0] a0;
        logic [3:0] a1;
        logic [3:0] a_end;
    } wv_t;

    initial begin
        wv_t        vec[4];
        logic       k0, k1, k2, k3;
        logic [7:0] rb;
        logic       s;

        vec[0] = '{8'h03, 8'hAA, 8'h55, 4'd3,  4'd4, 4'd5};
        vec[1] = '{8'h0F, 8'h12, 8'h34, 4'd15, 4'd0, 4'd1};
        vec[2] = '{8'hF7, 8'h00, 8'hFF, 4'd7,  4'd8, 4'd9};
        vec[3] = '{8'h0A, 8'hC3, 8'h3C, 4'd10, 4'd11, 4'd12};

        tick(3);
        check("rst_busy", busy, 0);
        check("rst_addr", reg_addr, 0);
        check("rst_wr_en", reg_wr_en, 0);
        check("rst_rd_en", reg_rd_en, 0);
        check("rst_sda", sda, 1);
        reset_n = 1'b1;
        tick(5);

        foreach (vec[i]) begin
            wr_exp.push_back({vec[i].a0, vec[i].d0});
            wr_exp.push_back({vec[i].a1, vec[i].d1});
            start_cond();
            send_byte(8'h84, -1, k0);
            check("wr_busy_mid", busy, 1);
            send_byte(vec[i].ptr, -1, k1);
            send_byte(vec[i].d0, -1, k2);
            send_byte(vec[i].d1, -1, k3);
            stop_cond();
            tick(Q);
            check("wr_acks", {k0, k1, k2, k3}, 4'hF);
            check("wr_busy_end", busy, 0);
            check("wr_addr_end", reg_addr, vec[i].a_end);
            check("wr_pending", wr_exp.size(), 0);
        end

        // read with repeated start, pointer wrapping 15 -> 0
        rd_exp.push_back(8'hEE);
        rd_exp.push_back(8'hFF);
        rd_exp.push_back(8'h00);
        start_cond();
        send_byte(8'h84, -1, k0);
        send_byte(8'h0E, -1, k1);
        rd_cnt = 0;
        start_cond();
        send_byte(8'h85, -1, k2);
        check("rd_acks", {k0, k1, k2}, 3'h7);
        for (int j = 0; j < 3; j++) begin
            recv_byte(j < 2, rb);
            check("rd_byte", rb, rd_exp.pop_front());
        end
        tick(Q);
        check("rd_sda_released", sda, 1);
        stop_cond();
        tick(Q);
        check("rd_en_count", rd_cnt, 3);
        check("rd_addr_end", reg_addr, 0);
        check("rd_busy_end", busy, 0);

        // address mismatch
        nd_watch = 1'b1;
        start_cond();
        send_byte(8'h86, -1, k0);
        send_byte(8'h01, -1, k1);
        stop_cond();
        tick(Q);
        nd_watch = 1'b0;
        check("mm_acks", {k0, k1}, 2'b00);
        check("mm_sda_driven", nd_viol, 0);
        check("mm_busy_seen", busy_hit, 0);
        check("mm_addr", reg_addr, 0);

        // glitches while idle and mid-byte
        tick(Q);
        scl_lo = 1'b1;
        tick(1);
        scl_lo = 1'b0;
        tick(Q);
        sda_lo = 1'b1;
        tick(1);
        sda_lo = 1'b0;
        tick(Q);
        check("gl_idle_busy", busy, 0);
        wr_exp.push_back({4'd6, 8'h5A});
        start_cond();
        send_byte(8'h84, 5, k0);
        send_byte(8'h06, 2, k1);
        send_byte(8'h5A, 0, k2);
        stop_cond();
        tick(Q);
        check("gl_acks", {k0, k1, k2}, 3'h7);
        check("gl_addr_end", reg_addr, 7);
        check("gl_pending", wr_exp.size(), 0);

        // reset during bit 4 of a read of register 2 (0x22, bit 4 is 0)
        start_cond();
        send_byte(8'h84, -1, k0);
        send_byte(8'h02, -1, k1);
        start_cond();
        send_byte(8'h85, -1, k2);
        for (int j = 0; j < 3; j++) bit_cycle(1'b1, 1'b0, s);
        tick(Q);
        sda_lo = 1'b0;
        tick(Q);
        scl_lo = 1'b0;
        tick(Q);
        check("rr_sda_before", sda, 0);
        reset_n = 1'b0;
        #1;
        check("rr_sda_after", sda, 1);
        check("rr_busy", busy, 0);
        check("rr_addr", reg_addr, 0);
        check("rr_wr_en", reg_wr_en, 0);
        check("rr_rd_en", reg_rd_en, 0);
        tick(2);
        reset_n = 1'b1;
        tick(Q);
        scl_lo = 1'b1;
        tick(Q);
        stop_cond();
        tick(Q);
        wr_exp.push_back({4'd9, 8'h77});
        start_cond();
        send_byte(8'h84, -1, k0);
        send_byte(8'h09, -1, k1);
        send_byte(8'h77, -1, k2);
        stop_cond();
        tick(Q);
        check("rr_next_acks", {k0, k1, k2}, 3'h7);
        check("rr_next_addr", reg_addr, 10);

        // stop after 5 bits of a data byte
        start_cond();
        send_byte(8'h84, -1, k0);
        send_byte(8'h05, -1, k1);
        for (int j = 7; j >= 3; j--) bit_cycle(j[0], 1'b0, s);
        stop_cond();
        tick(Q);
        check("sm_acks", {k0, k1}, 2'b11);
        check("sm_addr", reg_addr, 5);
        check("sm_busy", busy, 0);
        tick(4 * Q);
        check("final_pending", wr_exp.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: bench did not complete");
        $fatal(1);
    end
endmodule
